fu_result_arbiter: RTL and testbench

- Collection stage between the functional units and the ROB/CDB registers.
- Replaces the OR-reduction of FU result buses with per-FU result FIFOs, round-robin arbitration and a registered single-result output.
- At most one result per cycle goes to the ROB, plus the matching CDB broadcast.
- FUs see backpressure through fu_ready instead of relying on exclusive transmit.

---
 rtl/fu_result_arbiter_if.sv | 39 +++
 rtl/fu_result_arbiter.sv | 176 +++++++++++++++++
 tb/tb_fu_result_arbiter.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fu_result_arbiter_if.sv
// FU result / ROB / CDB bundle between the functional units and the result arbiter.
interface fu_result_arbiter_if #(
  parameter int unsigned FU_COUNT   = 8,
  parameter int unsigned FIFO_DEPTH = 2
);
  localparam int unsigned PEND_W = $clog2(FU_COUNT * FIFO_DEPTH + 1);

  logic [FU_COUNT-1:0]   fu_valid;
  logic [FU_COUNT-1:0]   fu_ready;
  logic [FU_COUNT*4-1:0] fu_robid;
  logic [FU_COUNT*8-1:0] fu_flags;
  logic [FU_COUNT*8-1:0] fu_wbs;
  logic [FU_COUNT*8-1:0] fu_value;
  logic [FU_COUNT-1:0]   fu_wb_en;
  logic                  rob_ready;
  logic                  rob_transmit;
  logic [3:0]            rob_id;
  logic [7:0]            rob_flags;
  logic [7:0]            rob_wbs;
  logic [7:0]            rob_value;
  logic                  cdb_transmit;
  logic [3:0]            cdb_id;
  logic [7:0]            cdb_val;
  logic [PEND_W-1:0]     pending;

  // Environment side: FUs and ROB.
  modport master (
    output fu_valid, fu_robid, fu_flags, fu_wbs, fu_value, fu_wb_en, rob_ready,
    input  fu_ready, rob_transmit, rob_id, rob_flags, rob_wbs, rob_value,
           cdb_transmit, cdb_id, cdb_val, pending
  );

  // Arbiter side.
  modport slave (
    input  fu_valid, fu_robid, fu_flags, fu_wbs, fu_value, fu_wb_en, rob_ready,
    output fu_ready, rob_transmit, rob_id, rob_flags, rob_wbs, rob_value,
           cdb_transmit, cdb_id, cdb_val, pending
  );
endinterface

// File: rtl/fu_result_arbiter.sv
// Per-FU result FIFOs, round-robin grant and a registered single-result ROB/CDB output.
module fu_result_arbiter #(
  parameter int unsigned FU_COUNT   = 8,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  fu_result_arbiter_if.slave bus
);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned IDX_W  = $clog2(FU_COUNT);
  localparam int unsigned PEND_W = $clog2(FU_COUNT * FIFO_DEPTH + 1);

  typedef struct packed {
    logic [3:0] robid;
    logic [7:0] flags;
    logic [7:0] wbs;
    logic [7:0] value;
    logic       wb_en;
  } result_t;

  result_t          mem_q    [FU_COUNT][FIFO_DEPTH];
  result_t          mem_d    [FU_COUNT][FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q [FU_COUNT];
  logic [PTR_W-1:0] rd_ptr_d [FU_COUNT];
  logic [PTR_W-1:0] wr_ptr_q [FU_COUNT];
  logic [PTR_W-1:0] wr_ptr_d [FU_COUNT];
  logic [CNT_W-1:0] count_q  [FU_COUNT];
  logic [CNT_W-1:0] count_d  [FU_COUNT];

  logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                out_valid_q, out_valid_d;
  result_t             out_q, out_d;
  logic [FU_COUNT-1:0] fu_ready_q, fu_ready_d;
  logic [PEND_W-1:0]   pending_q, pending_d;
  logic                cdb_transmit_q, cdb_transmit_d;
  logic [3:0]          cdb_id_q, cdb_id_d;
  logic [7:0]          cdb_val_q, cdb_val_d;

  logic                load;
  logic                found;
  logic [IDX_W-1:0]    grant;
  logic [IDX_W-1:0]    scan_idx;
  int unsigned         scan_sum;
  logic [FU_COUNT-1:0] push;
  logic [FU_COUNT-1:0] pop;

  // Round-robin scan from rr_ptr over FIFO occupancy at the start of the cycle.
  always_comb begin
    found    = 1'b0;
    grant    = rr_ptr_q;
    scan_sum = 0;
    scan_idx = '0;
    for (int k = 0; k < int'(FU_COUNT); k++) begin
      scan_sum = 32'(rr_ptr_q) + 32'(k);
      if (scan_sum >= FU_COUNT) scan_sum = scan_sum - FU_COUNT;
      scan_idx = IDX_W'(scan_sum);
      if (!found && (count_q[scan_idx] != '0)) begin
        found = 1'b1;
        grant = scan_idx;
      end
    end
  end

  // Push/pop strobes; fu_ready is the registered not-full flag so a full FIFO never accepts.
  always_comb begin
    load = !out_valid_q || bus.rob_ready;
    push = '0;
    pop  = '0;
    for (int i = 0; i < int'(FU_COUNT); i++) begin
      push[i] = bus.fu_valid[i] && fu_ready_q[i];
      pop[i]  = load && found && (grant == IDX_W'(i));
    end
  end

  // Next-state for FIFOs, output register, rr pointer and derived registered outputs.
  always_comb begin
    mem_d       = mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_d       = out_q;
    fu_ready_d  = '0;
    pending_d   = '0;

    if (flush) begin
      for (int i = 0; i < int'(FU_COUNT); i++) begin
        rd_ptr_d[i] = '0;
        wr_ptr_d[i] = '0;
        count_d[i]  = '0;
      end
      out_valid_d = 1'b0;
      out_d       = '0;
    end else begin
      for (int i = 0; i < int'(FU_COUNT); i++) begin
        if (push[i]) begin
          mem_d[i][wr_ptr_q[i]] = '{robid: bus.fu_robid[4*i +: 4],
                                    flags: bus.fu_flags[8*i +: 8],
                                    wbs:   bus.fu_wbs[8*i +: 8],
                                    value: bus.fu_value[8*i +: 8],
                                    wb_en: bus.fu_wb_en[i]};
          wr_ptr_d[i] = wr_ptr_q[i] + 1'b1;
        end
        if (pop[i]) rd_ptr_d[i] = rd_ptr_q[i] + 1'b1;
        count_d[i] = count_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
      if (load) begin
        if (found) begin
          out_valid_d = 1'b1;
          out_d       = mem_q[grant][rd_ptr_q[grant]];
          rr_ptr_d    = (grant == IDX_W'(FU_COUNT - 1)) ? '0 : grant + 1'b1;
        end else begin
          out_valid_d = 1'b0;
          out_d       = '0;
        end
      end
    end

    for (int i = 0; i < int'(FU_COUNT); i++) begin
      fu_ready_d[i] = count_d[i] < CNT_W'(FIFO_DEPTH);
      pending_d     = pending_d + PEND_W'(count_d[i]);
    end
    cdb_transmit_d = out_valid_d && out_d.wb_en;
    cdb_id_d       = cdb_transmit_d ? out_d.wbs[3:0] : 4'h0;
    cdb_val_d      = cdb_transmit_d ? out_d.value : 8'h00;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(FU_COUNT); i++) begin
        for (int j = 0; j < int'(FIFO_DEPTH); j++) mem_q[i][j] <= '0;
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      rr_ptr_q       <= '0;
      out_valid_q    <= 1'b0;
      out_q          <= '0;
      fu_ready_q     <= '1;
      pending_q      <= '0;
      cdb_transmit_q <= 1'b0;
      cdb_id_q       <= '0;
      cdb_val_q      <= '0;
    end else begin
      mem_q          <= mem_d;
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      rr_ptr_q       <= rr_ptr_d;
      out_valid_q    <= out_valid_d;
      out_q          <= out_d;
      fu_ready_q     <= fu_ready_d;
      pending_q      <= pending_d;
      cdb_transmit_q <= cdb_transmit_d;
      cdb_id_q       <= cdb_id_d;
      cdb_val_q      <= cdb_val_d;
    end
  end

  assign bus.fu_ready     = fu_ready_q;
  assign bus.rob_transmit = out_valid_q;
  assign bus.rob_id       = out_q.robid;
  assign bus.rob_flags    = out_q.flags;
  assign bus.rob_wbs      = out_q.wbs;
  assign bus.rob_value    = out_q.value;
  assign bus.cdb_transmit = cdb_transmit_q;
  assign bus.cdb_id       = cdb_id_q;
  assign bus.cdb_val      = cdb_val_q;
  assign bus.pending      = pending_q;

endmodule

// File: tb/tb_fu_result_arbiter.sv
// Directed bench for fu_result_arbiter: FU_COUNT=8, FIFO_DEPTH=2.
module tb_fu_result_arbiter;
  logic clk;
  logic rst;
  logic flush;
  int   total;
  int   bad;

  fu_result_arbiter_if #(.FU_COUNT(8), .FIFO_DEPTH(2)) bus ();

  fu_result_arbiter #(.FU_COUNT(8), .FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fu();
    bus.fu_valid = '0;
    bus.fu_robid = '0;
    bus.fu_flags = '0;
    bus.fu_wbs   = '0;
    bus.fu_value = '0;
    bus.fu_wb_en = '0;
  endtask

  task automatic drive_fu(input int i, input logic [3:0] robid, input logic [7:0] flags,
                          input logic [7:0] wbs, input logic [7:0] value, input logic wb_en);
    bus.fu_valid[i]        = 1'b1;
    bus.fu_robid[4*i +: 4] = robid;
    bus.fu_flags[8*i +: 8] = flags;
    bus.fu_wbs[8*i +: 8]   = wbs;
    bus.fu_value[8*i +: 8] = value;
    bus.fu_wb_en[i]        = wb_en;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    flush = 1'b0;
    bus.rob_ready = 1'b0;
    clear_fu();

    // Reset state
    #1 rst = 1'b0;
    #1;
    chk("rst_transmit", 32'(bus.rob_transmit), 32'h0);
    chk("rst_ready",    32'(bus.fu_ready),     32'hFF);
    chk("rst_pending",  32'(bus.pending),      32'h0);
    chk("rst_cdb",      32'(bus.cdb_transmit), 32'h0);
    chk("rst_robid",    32'(bus.rob_id),       32'h0);
    #10 rst = 1'b1;

    // Round robin from rr_ptr=0: FU0, FU3, FU7
    bus.rob_ready = 1'b1;
    drive_fu(0, 4'h1, 8'h10, 8'h21, 8'hA0, 1'b1);
    drive_fu(3, 4'h3, 8'h13, 8'h43, 8'hA3, 1'b0);
    drive_fu(7, 4'h7, 8'h17, 8'h65, 8'hA7, 1'b1);
    step();
    clear_fu();
    chk("rr_push_pending", 32'(bus.pending), 32'd3);
    chk("rr_push_tx",      32'(bus.rob_transmit), 32'h0);
    step();
    chk("rr0_tx",     32'(bus.rob_transmit), 32'h1);
    chk("rr0_id",     32'(bus.rob_id), 32'h1);
    chk("rr0_val",    32'(bus.rob_value), 32'hA0);
    chk("rr0_cdb",    32'(bus.cdb_transmit), 32'h1);
    chk("rr0_cdbid",  32'(bus.cdb_id), 32'h1);
    chk("rr0_cdbval", 32'(bus.cdb_val), 32'hA0);
    chk("rr0_pend",   32'(bus.pending), 32'd2);
    step();
    chk("rr3_id",     32'(bus.rob_id), 32'h3);
    chk("rr3_flags",  32'(bus.rob_flags), 32'h13);
    chk("rr3_cdb",    32'(bus.cdb_transmit), 32'h0);
    chk("rr3_cdbval", 32'(bus.cdb_val), 32'h0);
    chk("rr3_pend",   32'(bus.pending), 32'd1);
    step();
    chk("rr7_id",    32'(bus.rob_id), 32'h7);
    chk("rr7_cdbid", 32'(bus.cdb_id), 32'h5);
    chk("rr7_pend",  32'(bus.pending), 32'd0);
    drive_fu(0, 4'h8, 8'h00, 8'h32, 8'hB0, 1'b1);
    drive_fu(3, 4'h9, 8'h00, 8'h54, 8'hB3, 1'b1);
    step();
    clear_fu();
    chk("rr2_idle_tx", 32'(bus.rob_transmit), 32'h0);
    chk("rr2_pend",    32'(bus.pending), 32'd2);
    step();
    chk("rr2_first",  32'(bus.rob_id), 32'h8);
    step();
    chk("rr2_second", 32'(bus.rob_id), 32'h9);
    step();
    chk("rr2_done",   32'(bus.rob_transmit), 32'h0);

    // Single result through FU2
    drive_fu(2, 4'h5, 8'hA5, 8'h17, 8'h3C, 1'b1);
    step();
    clear_fu();
    chk("s_push_tx",   32'(bus.rob_transmit), 32'h0);
    chk("s_push_pend", 32'(bus.pending), 32'd1);
    step();
    chk("s_tx",     32'(bus.rob_transmit), 32'h1);
    chk("s_id",     32'(bus.rob_id), 32'h5);
    chk("s_flags",  32'(bus.rob_flags), 32'hA5);
    chk("s_wbs",    32'(bus.rob_wbs), 32'h17);
    chk("s_val",    32'(bus.rob_value), 32'h3C);
    chk("s_cdb",    32'(bus.cdb_transmit), 32'h1);
    chk("s_cdbid",  32'(bus.cdb_id), 32'h7);
    chk("s_cdbval", 32'(bus.cdb_val), 32'h3C);
    step();
    chk("s_after_tx",  32'(bus.rob_transmit), 32'h0);
    chk("s_after_cdb", 32'(bus.cdb_transmit), 32'h0);

    // Backpressure on FU1 with rob_ready low
    bus.rob_ready = 1'b0;
    drive_fu(1, 4'hA, 8'h00, 8'h00, 8'h10, 1'b0);
    step();
    chk("bp1_pend", 32'(bus.pending), 32'd1);
    chk("bp1_tx",   32'(bus.rob_transmit), 32'h0);
    drive_fu(1, 4'hB, 8'h00, 8'h00, 8'h11, 1'b0);
    step();
    chk("bp2_tx",   32'(bus.rob_transmit), 32'h1);
    chk("bp2_id",   32'(bus.rob_id), 32'hA);
    chk("bp2_pend", 32'(bus.pending), 32'd1);
    drive_fu(1, 4'hC, 8'h00, 8'h00, 8'h12, 1'b0);
    step();
    chk("bp3_pend",  32'(bus.pending), 32'd2);
    chk("bp3_ready", 32'(bus.fu_ready), 32'hFD);
    chk("bp3_id",    32'(bus.rob_id), 32'hA);
    drive_fu(1, 4'hD, 8'h00, 8'h00, 8'h13, 1'b0);
    step();
    chk("bp4_pend",  32'(bus.pending), 32'd2);
    chk("bp4_ready", 32'(bus.fu_ready), 32'hFD);
    chk("bp4_tx",    32'(bus.rob_transmit), 32'h1);
    chk("bp4_id",    32'(bus.rob_id), 32'hA);
    clear_fu();
    bus.rob_ready = 1'b1;
    step();
    chk("bp5_id",    32'(bus.rob_id), 32'hB);
    chk("bp5_pend",  32'(bus.pending), 32'd1);
    chk("bp5_ready", 32'(bus.fu_ready), 32'hFF);
    step();
    chk("bp6_id",   32'(bus.rob_id), 32'hC);
    chk("bp6_val",  32'(bus.rob_value), 32'h12);
    chk("bp6_pend", 32'(bus.pending), 32'd0);
    step();
    chk("bp7_tx", 32'(bus.rob_transmit), 32'h0);

    // Result without register write: no CDB broadcast
    drive_fu(5, 4'h4, 8'h01, 8'h2E, 8'h77, 1'b0);
    step();
    clear_fu();
    step();
    chk("nc_tx",     32'(bus.rob_transmit), 32'h1);
    chk("nc_id",     32'(bus.rob_id), 32'h4);
    chk("nc_wbs",    32'(bus.rob_wbs), 32'h2E);
    chk("nc_val",    32'(bus.rob_value), 32'h77);
    chk("nc_cdb",    32'(bus.cdb_transmit), 32'h0);
    chk("nc_cdbid",  32'(bus.cdb_id), 32'h0);
    chk("nc_cdbval", 32'(bus.cdb_val), 32'h0);
    step();
    chk("nc_after_tx", 32'(bus.rob_transmit), 32'h0);

    // Flush with 5 pending plus a valid output and a concurrent push
    bus.rob_ready = 1'b0;
    for (int i = 0; i < 5; i++) drive_fu(i, 4'(i + 1), 8'h00, 8'h00, 8'(8'hC0 + i), 1'b1);
    step();
    clear_fu();
    chk("fl1_pend", 32'(bus.pending), 32'd5);
    chk("fl1_tx",   32'(bus.rob_transmit), 32'h0);
    drive_fu(5, 4'h6, 8'h00, 8'h00, 8'hC5, 1'b1);
    step();
    clear_fu();
    chk("fl2_pend", 32'(bus.pending), 32'd5);
    chk("fl2_tx",   32'(bus.rob_transmit), 32'h1);
    chk("fl2_id",   32'(bus.rob_id), 32'h1);
    flush = 1'b1;
    drive_fu(6, 4'hF, 8'h00, 8'h00, 8'hEE, 1'b1);
    step();
    flush = 1'b0;
    clear_fu();
    chk("fl3_tx",    32'(bus.rob_transmit), 32'h0);
    chk("fl3_pend",  32'(bus.pending), 32'd0);
    chk("fl3_ready", 32'(bus.fu_ready), 32'hFF);
    bus.rob_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("fl_post_tx",   32'(bus.rob_transmit), 32'h0);
      chk("fl_post_pend", 32'(bus.pending), 32'd0);
    end

    // Asynchronous reset mid-cycle with a valid output
    bus.rob_ready = 1'b0;
    drive_fu(4, 4'h6, 8'h00, 8'h11, 8'h66, 1'b1);
    step();
    clear_fu();
    drive_fu(3, 4'h3, 8'h00, 8'h00, 8'h33, 1'b0);
    step();
    clear_fu();
    chk("ar_pre_tx",   32'(bus.rob_transmit), 32'h1);
    chk("ar_pre_id",   32'(bus.rob_id), 32'h6);
    chk("ar_pre_pend", 32'(bus.pending), 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("ar_tx",    32'(bus.rob_transmit), 32'h0);
    chk("ar_cdb",   32'(bus.cdb_transmit), 32'h0);
    chk("ar_pend",  32'(bus.pending), 32'd0);
    chk("ar_ready", 32'(bus.fu_ready), 32'hFF);
    #1 rst = 1'b1;
    bus.rob_ready = 1'b1;
    drive_fu(6, 4'hE, 8'h00, 8'h00, 8'h6E, 1'b0);
    drive_fu(1, 4'h2, 8'h00, 8'h00, 8'h61, 1'b0);
    step();
    clear_fu();
    chk("ar_push_pend", 32'(bus.pending), 32'd2);
    chk("ar_push_tx",   32'(bus.rob_transmit), 32'h0);
    step();
    chk("ar_first",  32'(bus.rob_id), 32'h2);
    step();
    chk("ar_second", 32'(bus.rob_id), 32'hE);
    step();
    chk("ar_done",   32'(bus.rob_transmit), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
